// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM write engine.
// State encoding, SRAM geometry, bus-phase helper.
package sram_pkg;

    localparam int SRAM_DEPTH = 32768;
    localparam int ADDR_W     = $clog2(SRAM_DEPTH);
    localparam int DATA_W     = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_DONE
    } state_t;

    function automatic logic bus_phase(input state_t s);
        return (s == S_SETUP) || (s == S_PULSE) || (s == S_HOLD);
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable 4-bit down-counter timing the write-strobe width.
// Ports: clk, reset_n, load, load_val[3:0], dec -> zero.
module sram_wait_counter (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    assign zero = (count == 4'd0);

endmodule

// File: rtl/sram_write_engine.sv
// Moves WR_DATA_NUM words from the data-in FIFO into async SRAM.
// Ports: start/addr/count in, RunEnd/Busy out, FIFO rd side,
// SRAM bus (ADDR, DQ_out, DQ_oe, CE/WE/OE/UB/LB_n).
// Macro SRAM_WR_STATUS_EN adds WR_WORD_TOTAL and WR_Stall.
module sram_write_engine
    import sram_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              WR_iRunStart,
    input  logic [ADDR_W-1:0] WR_START_ADDR,
    input  logic [ADDR_W-1:0] WR_DATA_NUM,
    output logic              WR_RunEnd,
    output logic              WR_Busy,
    output logic              SRAM_FIFO_rdreq,
    input  logic [DATA_W-1:0] SRAM_FIFO_q,
    input  logic              SRAM_FIFO_empty,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic [DATA_W-1:0] SRAM_DQ_out,
    output logic              SRAM_DQ_oe,
    output logic              SRAM_CE_n,
    output logic              SRAM_WE_n,
    output logic              SRAM_OE_n,
    output logic              SRAM_UB_n,
    output logic              SRAM_LB_n
`ifdef SRAM_WR_STATUS_EN
    ,
    output logic [31:0]       WR_WORD_TOTAL,
    output logic              WR_Stall
`endif
);

    state_t state, next;

    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] remain;
    logic [DATA_W-1:0] data;
    logic              rdreq_q, rdreq_d;
    logic              runend, busy, ce_n, we_n, oe;
    logic              wc_load, wc_dec, wc_zero;

    sram_wait_counter u_wait (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (wc_load),
        .load_val (4'(WAIT_CYCLES - 1)),
        .dec      (wc_dec),
        .zero     (wc_zero)
    );

    // FETCH leaves once the registered rdreq has been out for a cycle;
    // rdreq itself is looked up one edge early from the next state.
    always_comb begin
        next    = state;
        wc_load = 1'b0;
        wc_dec  = 1'b0;
        case (state)
            S_IDLE: begin
                if (WR_iRunStart) begin
                    next = (WR_DATA_NUM == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (rdreq_q) next = S_LATCH;
            end
            S_LATCH: next = S_SETUP;
            S_SETUP: begin
                next    = S_PULSE;
                wc_load = 1'b1;
            end
            S_PULSE: begin
                if (wc_zero) next = S_HOLD;
                else         wc_dec = 1'b1;
            end
            S_HOLD: begin
                next = (remain == ADDR_W'(1)) ? S_DONE : S_FETCH;
            end
            S_DONE:  next = S_IDLE;
            default: next = S_IDLE;
        endcase
        rdreq_d = (next == S_FETCH) && !SRAM_FIFO_empty;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            addr    <= '0;
            remain  <= '0;
            data    <= '0;
            rdreq_q <= 1'b0;
            runend  <= 1'b0;
            busy    <= 1'b0;
            ce_n    <= 1'b1;
            we_n    <= 1'b1;
            oe      <= 1'b0;
        end else begin
            state   <= next;
            rdreq_q <= rdreq_d;
            runend  <= (next == S_DONE);
            busy    <= (next != S_IDLE);
            ce_n    <= !bus_phase(next);
            we_n    <= (next != S_PULSE);
            oe      <= bus_phase(next);
            if ((state == S_IDLE) && WR_iRunStart) begin
                addr   <= WR_START_ADDR;
                remain <= WR_DATA_NUM;
            end
            if (state == S_LATCH) data <= SRAM_FIFO_q;
            if (state == S_HOLD) begin
                addr   <= addr + 1'b1;
                remain <= remain - 1'b1;
            end
        end
    end

    assign WR_RunEnd       = runend;
    assign WR_Busy         = busy;
    assign SRAM_FIFO_rdreq = rdreq_q;
    assign SRAM_ADDR       = addr;
    assign SRAM_DQ_out     = data;
    assign SRAM_DQ_oe      = oe;
    assign SRAM_CE_n       = ce_n;
    assign SRAM_WE_n       = we_n;
    assign SRAM_OE_n       = 1'b1;
    assign SRAM_UB_n       = ce_n;
    assign SRAM_LB_n       = ce_n;

`ifdef SRAM_WR_STATUS_EN
    logic [31:0] total;
    logic        stall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            total <= '0;
            stall <= 1'b0;
        end else begin
            if (state == S_HOLD) total <= total + 32'd1;
            stall <= (next == S_FETCH) && SRAM_FIFO_empty;
        end
    end

    assign WR_WORD_TOTAL = total;
    assign WR_Stall      = stall;
`endif

endmodule

// File: doc/sram_write_engine.md
# sram_write_engine

Write-side SRAM access engine sitting directly below the SRAM write/read sequencer. On a one-cycle start pulse it transfers a commanded number of 16-bit words from the data-in FIFO (normal, non-show-ahead mode) into the external asynchronous SRAM, starting at a commanded address, then returns a one-cycle completion pulse. A top-level mux hands the SRAM bus to this block whenever `WR_Busy` is high.

## Interface
- `WAIT_CYCLES`, default 2: write-strobe (`SRAM_WE_n` low) width in clocks; legal range 1–15.
- `clk` input 1: system clock; the only clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `WR_iRunStart` input 1: start pulse; sampled only in IDLE.
- `WR_START_ADDR` input 15: first SRAM word address; latched at start.
- `WR_DATA_NUM` input 15: word count; latched at start.
- `WR_RunEnd` output 1: one-cycle completion pulse.
- `WR_Busy` output 1: high in every state except IDLE.
- `SRAM_FIFO_rdreq` output 1: FIFO read request.
- `SRAM_FIFO_q` input 16: FIFO data, valid the cycle after `rdreq`.
- `SRAM_FIFO_empty` input 1: FIFO empty flag.
- `SRAM_ADDR` output 15: SRAM address.
- `SRAM_DQ_out` output 16: write data.
- `SRAM_DQ_oe` output 1: data-bus drive enable, used by the top-level tristate.
- `SRAM_CE_n`, `SRAM_WE_n`, `SRAM_OE_n`, `SRAM_UB_n`, `SRAM_LB_n` outputs 1 each: SRAM controls.

## Operation
- States: IDLE, FETCH, LATCH, SETUP, PULSE, HOLD, DONE.
- IDLE: if `WR_iRunStart`, latch address and count. Go to DONE if the count is 0, otherwise go to FETCH.
- FETCH: if `!SRAM_FIFO_empty`, assert `SRAM_FIFO_rdreq` for exactly this cycle and go to LATCH. Otherwise stall in FETCH with `rdreq` low.
- LATCH: capture `SRAM_FIFO_q` into the data register, then go to SETUP.
- SETUP: drive `SRAM_ADDR` and data, `CE_n`=0, `UB_n`/`LB_n`=0, `SRAM_DQ_oe`=1, `WE_n`=1.
- PULSE: hold `WE_n`=0 for exactly WAIT_CYCLES cycles, using a 4-bit down-counter. Address and data stay stable.
- HOLD: `WE_n`=1 while data and address are still driven. The address increments modulo 2^15 (0x7FFF wraps to 0x0000) and the remaining count decrements. If the remaining count reaches 0, go to DONE; otherwise go to FETCH.
- DONE: `WR_RunEnd`=1 for this single cycle, then go to IDLE.
- Default/illegal state: go to IDLE.
- `SRAM_OE_n` is always 1.
- `SRAM_CE_n`, `UB_n`, `LB_n` are low only in SETUP, PULSE and HOLD; they are 1 elsewhere.
- `SRAM_DQ_oe` is high only in SETUP, PULSE and HOLD.
- Start pulse while busy: ignored; no effect on the transfer in progress.
- The FIFO going empty mid-burst only stalls the transfer in FETCH; the SRAM bus stays released (CE_n=1, oe=0) during the stall.
- Reset mid-transfer: immediate return to IDLE with all outputs at reset values. The partial transfer is abandoned and no `WR_RunEnd` is issued.

## Timing
- Reset values:
  - `WR_RunEnd`=0, `WR_Busy`=0, `SRAM_FIFO_rdreq`=0.
  - `SRAM_ADDR`=0, `SRAM_DQ_out`=0, `SRAM_DQ_oe`=0.
  - `CE_n`/`WE_n`/`OE_n`/`UB_n`/`LB_n`=1.
- All outputs are registered.
- Per-word cost with a non-empty FIFO: WAIT_CYCLES+4 clocks.
- With start sampled at cycle 0 and the FIFO never empty:
  - Word k occupies FETCH at cycle 1+(W+4)k through HOLD at (W+4)(k+1).
  - `WR_RunEnd` is high at cycle N(W+4)+1.
- Zero-count start at cycle 0: `WR_RunEnd` is high at cycle 1.
- `WR_Busy` rises the cycle after start is sampled and falls the cycle after DONE.

## Configuration
- Macro `SRAM_WR_STATUS_EN`.
- Defined: adds output `WR_WORD_TOTAL` [31:0] and output `WR_Stall`.
  - `WR_WORD_TOTAL` counts every completed HOLD since reset, wraps at 2^32, and resets to 0.
  - `WR_Stall` is high in every cycle spent in FETCH with the FIFO empty; its reset value is 0.
- Undefined: neither port exists, and behaviour is otherwise identical.

## Structure
- Shared package `sram_pkg`:
  - state encoding (3-bit enumerated type);
  - SRAM address width 15 and data width 16;
  - SRAM depth constant 32768.
- One sub-module, `sram_wait_counter`: a loadable 4-bit down-counter with a `zero` flag, used for the PULSE state.

## Test plan
- N=4, W=2, start address 0x0010, FIFO preloaded with 0xA000–0xA003 → SRAM writes 0xA000..0xA003 to 0x0010..0x0013; `WE_n` low exactly 2 cycles per word; `WR_RunEnd` high at cycle 25 only.
- N=1024, W=2, FIFO kept full → `WR_RunEnd` at cycle 6145; exactly 1024 `rdreq` pulses.
- Start address 0x7FFE, N=4 → writes go to 0x7FFE, 0x7FFF, 0x0000, 0x0001.
- FIFO empty for 10 cycles before word 2 → stall in FETCH with CE_n=1 and oe=0; completion is delayed by exactly 10 cycles; data order is preserved.
- N=0 → `WR_RunEnd` at cycle 1; no `rdreq`; `CE_n` never low. A second `WR_iRunStart` pulse issued mid-burst → ignored, and the address sequence is unchanged.
- `reset_n` asserted during PULSE → all outputs reach reset values immediately; no `WR_RunEnd`. A new start after reset runs from the newly latched address.
